// File: rtl/osc_code_sequencer.sv
// rtl/osc_code_sequencer.sv - ring DCO per-stage delay-code ramp sequencer with LFSR dither
// Stages step one LSB at a time in round-robin so adjacent ring phases stay within one LSB.
module osc_code_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int LSB_W      = 5,
    parameter int MSB_W      = 8,
    parameter int PERB_W     = 4,
    parameter int SETTLE_CYC = 4,
    parameter int TGT_W      = $clog2(MSB_W + 1) + LSB_W
) (
    input  logic                         ref_clk,
    input  logic                         rst,
    input  logic                         glob_en,
    input  logic [TGT_W-1:0]             tgt_code,
    input  logic                         tgt_valid,
    output logic                         tgt_ready,
    input  logic                         dither_en,
    output logic [NUM_STAGES*LSB_W-1:0]  delay_con_lsb,
    output logic [NUM_STAGES*MSB_W-1:0]  delay_con_msb,
    output logic [NUM_STAGES*PERB_W-1:0] con_perb,
    output logic                         busy,
    output logic                         done
);

    localparam int MAX_CODE = (MSB_W + 1) * (2 ** LSB_W) - 1;
    localparam int PTR_W    = $clog2(NUM_STAGES);
    localparam int CNT_W    = $clog2(SETTLE_CYC + 1);
    localparam int CRS_W    = TGT_W - LSB_W;

    localparam logic [TGT_W-1:0] MAX_V    = TGT_W'(MAX_CODE);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMP,
        S_SETTLE
    } state_t;

    state_t             state_q, state_d;
    logic [TGT_W-1:0]   code_q [NUM_STAGES];
    logic [TGT_W-1:0]   code_d [NUM_STAGES];
    logic [TGT_W-1:0]   tgt_q, tgt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [TGT_W-1:0]   cur, stepped;
    logic               all_eq;

    logic [15:0]                  lfsr_q, lfsr_n;
    logic                         lfsr_fb;
    logic [NUM_STAGES*PERB_W-1:0] perb_q, perb_d;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        tgt_d   = tgt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        cur     = code_q[ptr_q];
        stepped = cur;
        all_eq  = 1'b1;

        if (cur < tgt_q) begin
            stepped = cur + TGT_W'(1);
        end else if (cur > tgt_q) begin
            stepped = cur - TGT_W'(1);
        end

        // Completion is judged on the codes as they will be after this cycle's step.
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (((PTR_W'(i) == ptr_q) ? stepped : code_q[i]) != tgt_q) begin
                all_eq = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (tgt_valid) begin
                    tgt_d   = (tgt_code > MAX_V) ? MAX_V : tgt_code;
                    ptr_d   = '0;
                    state_d = S_RAMP;
                end
            end
            S_RAMP: begin
                code_d[ptr_q] = stepped;
                if (ptr_q == LAST_PTR) begin
                    ptr_d = '0;
                    if (all_eq) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Disabling aborts everything but leaves the bank codes where they are.
        if (!glob_en) begin
            state_d = S_IDLE;
            code_d  = code_q;
            tgt_d   = tgt_q;
            done_d  = 1'b0;
        end
    end

    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign lfsr_n  = (dither_en && glob_en) ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;

    always_comb begin
        perb_d = '0;
        if (dither_en) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                perb_d[i*PERB_W +: PERB_W] = lfsr_n[PERB_W-1:0] ^ PERB_W'(i);
            end
        end
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int i = 0; i < NUM_STAGES; i++) begin
                code_q[i] <= '0;
            end
            tgt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            lfsr_q  <= 16'hACE1;
            perb_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            tgt_q   <= tgt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            lfsr_q  <= lfsr_n;
            perb_q  <= perb_d;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            assign delay_con_lsb[gi*LSB_W +: LSB_W] = code_q[gi][LSB_W-1:0];
            for (gj = 0; gj < MSB_W; gj++) begin : g_therm
                assign delay_con_msb[gi*MSB_W + gj] = (code_q[gi][TGT_W-1:LSB_W] > CRS_W'(gj));
            end
        end
    endgenerate

    assign tgt_ready = !rst && (state_q == S_IDLE) && glob_en;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign con_perb  = perb_q;

endmodule

// File: tb/tb_osc_code_sequencer.sv
// tb/tb_osc_code_sequencer.sv - self-checking bench for osc_code_sequencer
// A schedule-based model predicts every output each cycle; directed cases pin it with literals.
module tb_osc_code_sequencer;

    localparam int N    = 5;
    localparam int LW   = 5;
    localparam int MW   = 8;
    localparam int PW   = 4;
    localparam int SC   = 4;
    localparam int TW   = 9;
    localparam int MAXC = 287;

    logic          ref_clk = 1'b0;
    logic          rst, glob_en, tgt_valid, dither_en;
    logic [TW-1:0] tgt_code;
    logic          tgt_ready, busy, done;
    logic [N*LW-1:0] delay_con_lsb;
    logic [N*MW-1:0] delay_con_msb;
    logic [N*PW-1:0] con_perb;

    osc_code_sequencer #(
        .NUM_STAGES(N), .LSB_W(LW), .MSB_W(MW), .PERB_W(PW), .SETTLE_CYC(SC), .TGT_W(TW)
    ) dut (
        .ref_clk(ref_clk), .rst(rst), .glob_en(glob_en), .tgt_code(tgt_code),
        .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .dither_en(dither_en),
        .delay_con_lsb(delay_con_lsb), .delay_con_msb(delay_con_msb),
        .con_perb(con_perb), .busy(busy), .done(done)
    );

    always #5 ref_clk = ~ref_clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit started = 0;
    bit inv_on = 0;

    int m_c [N];
    int m_perb [N];
    int m_tgt, m_t0, m_p;
    bit m_act, m_done;
    int m_lfsr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lsb_of(input int i);
        return int'(delay_con_lsb[i*LW +: LW]);
    endfunction

    function automatic int msb_of(input int i);
        return int'(delay_con_msb[i*MW +: MW]);
    endfunction

    function automatic int perb_of(input int i);
        return int'(con_perb[i*PW +: PW]);
    endfunction

    // Model: on acceptance the pass count is known up front, so the ramp is a fixed
    // schedule of single steps, one stage per cycle, followed by the settle window.
    always @(posedge ref_clk) begin
        int rel, k, d, fb;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_c[i] = 0;
                m_perb[i] = 0;
            end
            m_act = 0;
            m_done = 0;
            m_tgt = 0;
            m_lfsr = 16'hACE1;
            started = 1;
        end else begin
            m_done = 0;
            if (m_act) begin
                if (!glob_en) begin
                    m_act = 0;
                end else begin
                    rel = cyc - m_t0;
                    if (rel <= m_p * N) begin
                        k = (rel - 1) % N;
                        if (m_c[k] < m_tgt) m_c[k] = m_c[k] + 1;
                        else if (m_c[k] > m_tgt) m_c[k] = m_c[k] - 1;
                    end
                    if (rel == m_p * N + SC) begin
                        m_act = 0;
                        m_done = 1;
                    end
                end
            end else if (glob_en && tgt_valid) begin
                m_tgt = (int'(tgt_code) > MAXC) ? MAXC : int'(tgt_code);
                m_t0 = cyc;
                d = 0;
                for (int i = 0; i < N; i++) begin
                    if (m_c[i] - m_tgt > d) d = m_c[i] - m_tgt;
                    if (m_tgt - m_c[i] > d) d = m_tgt - m_c[i];
                end
                m_p = (d < 1) ? 1 : d;
                m_act = 1;
            end
            if (dither_en && glob_en) begin
                fb = ((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
                m_lfsr = (m_lfsr >> 1) | (fb << 15);
            end
            for (int i = 0; i < N; i++) m_perb[i] = dither_en ? ((m_lfsr & 15) ^ i) : 0;
        end
        cyc++;
    end

    always @(negedge ref_clk) begin
        int lo, hi, c;
        if (started) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("lsb[%0d]", i), lsb_of(i), m_c[i] % 32);
                chk($sformatf("msb[%0d]", i), msb_of(i), (1 << (m_c[i] / 32)) - 1);
                chk($sformatf("perb[%0d]", i), perb_of(i), m_perb[i]);
            end
            chk("busy", int'(busy), int'(m_act));
            chk("done", int'(done), int'(m_done));
            chk("tgt_ready", int'(tgt_ready), int'(glob_en && !m_act && !rst));
            if (inv_on) begin
                lo = 1000;
                hi = -1;
                for (int i = 0; i < N; i++) begin
                    c = $countones(delay_con_msb[i*MW +: MW]) * 32 + lsb_of(i);
                    if (c < lo) lo = c;
                    if (c > hi) hi = c;
                end
                chk("spread_le_1", int'(hi - lo <= 1), 1);
            end
        end
    end

    task automatic offer(input int code, output int t);
        bit hit;
        hit = 0;
        t = -1;
        @(posedge ref_clk); #1;
        tgt_code = TW'(code);
        tgt_valid = 1;
        for (int n = 0; n < 200; n++) begin
            @(negedge ref_clk);
            if (tgt_ready) begin
                t = cyc;
                hit = 1;
            end
            @(posedge ref_clk); #1;
            if (hit) break;
        end
        tgt_valid = 0;
        chk("accept_timeout", int'(hit), 1);
    endtask

    task automatic at_cycle(input int n);
        @(negedge ref_clk);
        while (cyc < n) @(negedge ref_clk);
    endtask

    task automatic wait_done(input int budget, output int t);
        t = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge ref_clk);
            if (done) begin
                t = cyc;
                break;
            end
        end
        chk("done_seen", int'(t >= 0), 1);
    endtask

    task automatic do_reset();
        @(posedge ref_clk); #1;
        rst = 1;
        @(posedge ref_clk); #1;
        rst = 0;
    endtask

    initial begin
        int t, td, c0;
        int acc [2];
        int na, dc;
        int lit [5];
        rst = 1;
        glob_en = 0;
        tgt_valid = 0;
        tgt_code = '0;
        dither_en = 0;
        @(posedge ref_clk); #1;
        glob_en = 1;
        @(negedge ref_clk);
        chk("ready_in_rst", int'(tgt_ready), 0);
        @(posedge ref_clk); #1;
        rst = 0;
        @(negedge ref_clk);
        chk("rst_lsb", int'(delay_con_lsb), 0);
        chk("rst_msb", int'(delay_con_msb), 0);
        chk("rst_perb", int'(con_perb), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(tgt_ready), 1);

        // Target 3 from zero
        inv_on = 1;
        offer(3, t);
        at_cycle(t + 2);
        chk("t1_s0_first_step", lsb_of(0), 1);
        chk("t1_s1_not_yet", lsb_of(1), 0);
        at_cycle(t + 16);
        for (int i = 0; i < N; i++) begin
            chk("t1_final_lsb", lsb_of(i), 3);
            chk("t1_final_msb", msb_of(i), 0);
        end
        wait_done(100, td);
        chk("t1_done_cycle", td - t, 20);

        // 31 -> 33 crosses a coarse boundary
        offer(31, t);
        wait_done(400, td);
        offer(33, t);
        at_cycle(t + 2);
        chk("t2_s0_lsb", lsb_of(0), 0);
        chk("t2_s0_msb", msb_of(0), 1);
        chk("t2_s1_lsb", lsb_of(1), 31);
        chk("t2_s1_msb", msb_of(1), 0);
        wait_done(100, td);
        chk("t2_done_cycle", td - t, 15);
        for (int i = 0; i < N; i++) begin
            chk("t2_final_lsb", lsb_of(i), 1);
            chk("t2_final_msb", msb_of(i), 1);
        end

        // Clamp to full scale from zero
        do_reset();
        offer(9'h1FF, t);
        wait_done(2000, td);
        chk("t3_done_cycle", td - t, 287 * 5 + 5);
        for (int i = 0; i < N; i++) begin
            chk("t3_final_lsb", lsb_of(i), 31);
            chk("t3_final_msb", msb_of(i), 8'hFF);
        end
        inv_on = 0;

        // Abort mid-ramp, then resume
        offer(100, t);
        at_cycle(t + 8);
        @(posedge ref_clk); #1;
        glob_en = 0;
        at_cycle(t + 10);
        chk("t4_busy_after_abort", int'(busy), 0);
        chk("t4_ready_after_abort", int'(tgt_ready), 0);
        chk("t4_s0_frozen", lsb_of(0), 29);
        chk("t4_s4_frozen", lsb_of(4), 30);
        at_cycle(t + 16);
        chk("t4_s0_still", lsb_of(0), 29);
        @(posedge ref_clk); #1;
        glob_en = 1;
        offer(100, t);
        wait_done(2000, td);
        chk("t4_done_cycle", td - t, 186 * 5 + 5);
        for (int i = 0; i < N; i++) begin
            chk("t4_final_lsb", lsb_of(i), 4);
            chk("t4_final_msb", msb_of(i), 8'h07);
        end

        // Held valid: accepted once, then again in the done cycle with D = 0
        @(posedge ref_clk); #1;
        tgt_code = TW'(40);
        tgt_valid = 1;
        na = 0;
        dc = -1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge ref_clk);
            if (tgt_ready) begin
                acc[na] = cyc;
                na++;
            end
            if (done && dc < 0) dc = cyc;
            @(posedge ref_clk); #1;
            if (na == 2) break;
        end
        tgt_valid = 0;
        chk("t5_two_accepts", na, 2);
        chk("t5_second_accept", acc[1] - acc[0], 305);
        chk("t5_done_with_accept", dc, acc[1]);
        wait_done(100, td);
        chk("t5_d0_done", td - acc[1], 10);

        // Dither sequence from seed
        do_reset();
        @(posedge ref_clk); #1;
        dither_en = 1;
        c0 = cyc;
        lit[1] = 4'h0;
        lit[2] = 4'h8;
        lit[3] = 4'hC;
        lit[4] = 4'hE;
        for (int k = 1; k <= 4; k++) begin
            at_cycle(c0 + k);
            chk("t6_perb0", perb_of(0), lit[k]);
            chk("t6_perb3", perb_of(3), lit[k] ^ 3);
        end
        @(posedge ref_clk); #1;
        dither_en = 0;
        c0 = cyc;
        at_cycle(c0 + 1);
        chk("t6_perb_off", int'(con_perb), 0);

        @(posedge ref_clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/osc_code_sequencer.md
# osc_code_sequencer

Parametrised, clocked control sequencer for an N-stage single-ended ring DCO. It accepts a target delay code through a valid/ready handshake and ramps every stage's varactor-bank code toward it, one LSB step per stage at a time in round-robin order, so adjacent ring phases never differ by more than one LSB during a retune. It also drives an LFSR-based perturbation (dither) code per stage. It sits between the PHY clock controller and the oscillator core's per-stage varactor banks.

## Interface
- NUM_STAGES, 5: ring stages driven (≥3)
- LSB_W, 5: binary fine-code width per stage
- MSB_W, 8: unary (thermometer) coarse-code width per stage
- PERB_W, 4: perturbation code width per stage (≤16)
- SETTLE_CYC, 4: settle cycles after ramp completes (≥1)
- TGT_W, $clog2(MSB_W+1)+LSB_W: target code width (derived)
- ref_clk  input  1  sole clock
- rst  input  1  synchronous, active-high reset
- glob_en  input  1  global enable; low aborts the ramp and freezes codes
- tgt_code  input  TGT_W  requested code = coarse_count·2^LSB_W + fine
- tgt_valid  input  1  target offered
- tgt_ready  output  1  target accepted when tgt_valid & tgt_ready
- dither_en  input  1  enables perturbation output
- delay_con_lsb  output  NUM_STAGES·LSB_W  per-stage fine code; stage i at [i·LSB_W +: LSB_W]
- delay_con_msb  output  NUM_STAGES·MSB_W  per-stage thermometer coarse code
- con_perb  output  NUM_STAGES·PERB_W  per-stage perturbation code
- busy  output  1  FSM not in IDLE
- done  output  1  one-cycle pulse when a retune completes

## Operation
- Each stage holds an internal code c_i, 0..MAX, where MAX = MSB_W·2^LSB_W + 2^LSB_W − 1 (287 at defaults).
- Output encoding: coarse = c_i >> LSB_W; fine = c_i[LSB_W-1:0]. The msb bus has the low `coarse` bits set and the rest clear.
- An accepted tgt_code above MAX is clamped to MAX.
- FSM states:
  - IDLE: tgt_ready = glob_en. A handshake registers the target, sets ptr = 0 and moves to RAMP.
  - RAMP: each cycle, stage ptr steps c_ptr by +1 or −1 toward the target, or holds if equal. ptr increments and wraps from NUM_STAGES−1 to 0.
    - At ptr = NUM_STAGES−1, if all post-update codes equal the target, move to SETTLE with cnt = 0. Otherwise stay in RAMP.
  - SETTLE: cnt increments each cycle. After SETTLE_CYC cycles, move to IDLE and pulse done in the first IDLE cycle.
- tgt_ready is low in RAMP and SETTLE; targets offered then are ignored. tgt_valid may be held until accepted.
- glob_en low in any state: next state is IDLE, codes hold their current values, no done pulse, tgt_ready = 0. A later target ramps from the held codes, which may differ by 1 between stages.
- Dither:
  - 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, seeded 16'hACE1.
  - Advances each cycle while dither_en & glob_en.
  - Registered con_perb stage i = lfsr[PERB_W-1:0] ^ i[PERB_W-1:0].
  - All con_perb are 0 while dither_en = 0.
- Invariant: at every cycle, max(c_i) − min(c_i) ≤ 1 after any ramp starting from equal codes.

## Timing
- Reset values: all codes 0 (lsb = 0, msb = 0), con_perb = 0, LFSR = 16'hACE1, state IDLE, busy = 0, done = 0, tgt_ready = 0 during rst. tgt_ready = glob_en from the first cycle after reset.
- Handshake in cycle T: RAMP occupies T+1 … T+P·NUM_STAGES, where P = max(D, 1) and D = max_i |target − c_i|.
- Stage 0's first step is visible on outputs in cycle T+2; stage k's first step in T+2+k.
- SETTLE occupies the next SETTLE_CYC cycles.
- done = 1 and tgt_ready = 1 in cycle T + P·NUM_STAGES + SETTLE_CYC + 1.
- D = 0 still runs one full pass plus settle, with no output change.
- busy = 1 exactly in the RAMP and SETTLE cycles.
- rst mid-operation returns everything to its reset values on the next edge and has priority over glob_en.
- con_perb changes no more than once per cycle; the first LFSR advance is visible the cycle after dither_en rises.

## Test plan
- Reset, glob_en = 1, target 3 at T → stage 0 reads 1 at T+2; all stages read lsb = 3 with msb = 0 by T+16; done pulses at T+20; busy high T+1…T+19.
- From code 31, target 33 → in cycle T+2 the outputs show stage 0 = 32 (lsb 0, msb 8'h01) and stage 1 = 31; the final code is lsb 1, msb 8'h01; adjacent-stage difference never exceeds 1.
- Target 9'h1FF → clamped to 287: lsb 31, msb 8'hFF on all stages; done at T + 287·5 + 5.
- glob_en dropped mid-ramp → the next cycle is IDLE with tgt_ready = 0 and codes frozen; there is no done pulse; re-enable plus a new target completes correctly.
- Targets offered with tgt_valid held during RAMP/SETTLE → not accepted until IDLE; the same target then yields D = 0, giving one pass, and done after 5 + 4 + 1 cycles.
- dither_en = 1 after reset → stage 0 con_perb follows LFSR bits [3:0] of the reference sequence from seed 16'hACE1; stage i = stage 0 ^ i; dither_en = 0 → all zero.
